// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// flush/hold control and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       RegWriteD,
    input  logic             ALUSrcD,
    input  logic [1:0]       MemWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic [5:0]       ALUControlD,
    input  logic             CSR_reg_wrD,
    input  logic             CSR_reg_rdD,
    input  logic [1:0]       CSR_wd_selectD,
    input  logic             RD1_RS1_selD,
    input  logic [2:0]       funct3D,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RdD,
    input  logic             FlushE,
    input  logic             StallE,
    output logic [2:0]       RegWriteE,
    output logic             ALUSrcE,
    output logic [1:0]       MemWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             BranchE,
    output logic             JumpE,
    output logic [5:0]       ALUControlE,
    output logic             CSR_reg_wrE,
    output logic             CSR_reg_rdE,
    output logic [1:0]       CSR_wd_selectE,
    output logic             RD1_RS1_selE,
    output logic [2:0]       funct3E,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       RS1E,
    output logic [4:0]       RS2E,
    output logic [4:0]       RdE,
    output logic             ValidE,
    output logic             StallF,
    output logic             StallD,
    output logic [CNT_W-1:0] BubbleCnt
);
    localparam int W = 39 + 5 * XLEN;
    logic [W-1:0]     d_vec, e_d, e_q;
    logic             valid_d, valid_q, hz;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    assign d_vec = {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, JumpD, ALUControlD,
                    CSR_reg_wrD, CSR_reg_rdD, CSR_wd_selectD, RD1_RS1_selD, funct3D,
                    RD1D, RD2D, ImmExtD, PCD, PCPlus4D, RS1D, RS2D, RdD};
    assign {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE,
            CSR_reg_wrE, CSR_reg_rdE, CSR_wd_selectE, RD1_RS1_selE, funct3E,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RS1E, RS2E, RdE} = e_q;
    assign ValidE    = valid_q;
    assign BubbleCnt = cnt_q;
    // Both sources are compared even when the instruction does not read RS2.
    assign hz = valid_q && ResultSrcE == 2'b01 && RegWriteE != 3'd0 && RdE != 5'd0 &&
                (RdE == RS1D || RdE == RS2D);
    assign StallF = (hz & ~FlushE) | StallE;
    assign StallD = StallF;
    always_comb begin
        e_d     = FlushE ? '0 : StallE ? e_q : hz ? '0 : d_vec;
        valid_d = ~FlushE & (StallE ? valid_q : ~hz);
        cnt_d   = (~FlushE & ~StallE & hz & ~&cnt_q) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            e_q     <= e_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a
// record-level model of the decode-to-execute register.
module tb_id_ex_stage;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    typedef struct packed {
        logic [2:0]  regwrite;
        logic        alusrc;
        logic [1:0]  memwrite;
        logic [1:0]  resultsrc;
        logic        branch;
        logic        jump;
        logic [5:0]  aluctl;
        logic        csr_wr;
        logic        csr_rd;
        logic [1:0]  csr_wdsel;
        logic        rd1sel;
        logic [2:0]  funct3;
        logic [31:0] rd1, rd2, imm, pc, pcp4;
        logic [4:0]  rs1, rs2, rd;
    } dv_t;
    logic clk, rst, flush, stall, chk_en;
    dv_t  d, saved, e_dut, m_e;
    logic m_v;
    int   m_cnt;
    int   checks, errors;
    logic [2:0]       RegWriteE;
    logic             ALUSrcE, BranchE, JumpE, CSR_reg_wrE, CSR_reg_rdE, RD1_RS1_selE;
    logic [1:0]       MemWriteE, ResultSrcE, CSR_wd_selectE;
    logic [5:0]       ALUControlE;
    logic [2:0]       funct3E;
    logic [31:0]      RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]       RS1E, RS2E, RdE;
    logic             ValidE, StallF, StallD;
    logic [CNT_W-1:0] BubbleCnt;
    id_ex_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(d.regwrite), .ALUSrcD(d.alusrc), .MemWriteD(d.memwrite),
        .ResultSrcD(d.resultsrc), .BranchD(d.branch), .JumpD(d.jump),
        .ALUControlD(d.aluctl), .CSR_reg_wrD(d.csr_wr), .CSR_reg_rdD(d.csr_rd),
        .CSR_wd_selectD(d.csr_wdsel), .RD1_RS1_selD(d.rd1sel), .funct3D(d.funct3),
        .RD1D(d.rd1), .RD2D(d.rd2), .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pcp4),
        .RS1D(d.rs1), .RS2D(d.rs2), .RdD(d.rd), .FlushE(flush), .StallE(stall),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUControlE(ALUControlE), .CSR_reg_wrE(CSR_reg_wrE), .CSR_reg_rdE(CSR_reg_rdE),
        .CSR_wd_selectE(CSR_wd_selectE), .RD1_RS1_selE(RD1_RS1_selE), .funct3E(funct3E),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RS1E(RS1E), .RS2E(RS2E), .RdE(RdE), .ValidE(ValidE), .StallF(StallF),
        .StallD(StallD), .BubbleCnt(BubbleCnt)
    );
    assign e_dut = {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE,
                    CSR_reg_wrE, CSR_reg_rdE, CSR_wd_selectE, RD1_RS1_selE, funct3E,
                    RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RS1E, RS2E, RdE};
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    function automatic logic hazard(dv_t e, logic v, dv_t nd);
        return v && e.resultsrc == 2'b01 && e.regwrite != 0 && e.rd != 0 &&
               (e.rd == nd.rs1 || e.rd == nd.rs2);
    endfunction
    // Model: E either holds a copy of an earlier D record or an all-zero bubble.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_e   <= '0;
            m_v   <= 1'b0;
            m_cnt <= 0;
        end else if (flush) begin
            m_e <= '0;
            m_v <= 1'b0;
        end else if (!stall) begin
            if (hazard(m_e, m_v, d)) begin
                m_e <= '0;
                m_v <= 1'b0;
                if (m_cnt < MAXC) m_cnt <= m_cnt + 1;
            end else begin
                m_e <= d;
                m_v <= 1'b1;
            end
        end
    end
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            logic exp_stall;
            exp_stall = (hazard(m_e, m_v, d) && !flush) || stall;
            checks += 5;
            if (e_dut !== m_e) begin
                errors++;
                $display("FAIL e_record got %h exp %h", e_dut, m_e);
            end
            if (ValidE !== m_v) begin
                errors++;
                $display("FAIL valid got %b exp %b", ValidE, m_v);
            end
            if (StallF !== exp_stall) begin
                errors++;
                $display("FAIL stallf got %b exp %b", StallF, exp_stall);
            end
            if (StallD !== exp_stall) begin
                errors++;
                $display("FAIL stalld got %b exp %b", StallD, exp_stall);
            end
            if (BubbleCnt !== m_cnt[CNT_W-1:0]) begin
                errors++;
                $display("FAIL bubble_cnt got %0d exp %0d", BubbleCnt, m_cnt);
            end
        end
    end
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask
    task automatic nxt();
        @(negedge clk);
    endtask
    task automatic rand_d();
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        d.rs1       = 5'($urandom_range(0, 3));
        d.rs2       = 5'($urandom_range(0, 3));
        d.rd        = 5'($urandom_range(0, 3));
        d.resultsrc = 2'($urandom_range(0, 3));
    endtask
    task automatic load_d(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        d = '0;
        d.resultsrc = 2'b01;
        d.regwrite  = 3'd1;
        d.rd = rd;
        d.rs1 = rs1;
        d.rs2 = rs2;
    endtask
    initial begin
        checks = 0;
        errors = 0;
        chk_en = 0;
        rst = 1;
        flush = 0;
        stall = 0;
        d = '0;
        #1 rst = 0;
        chk_en = 1;
        repeat (3) begin
            nxt(); rand_d(); #3;
            lit("rst_valid", ValidE, 0);
            lit("rst_cnt", BubbleCnt, 0);
            lit("rst_rd1", RD1E, 0);
            lit("rst_regwr", RegWriteE, 0);
        end
        nxt(); rand_d(); saved = d; rst = 1;
        nxt();
        d = '0; d.aluctl = 6'h05; d.rd1 = 32'h1234_5678; d.rd = 5'd7;
        #3;
        lit("rel_valid", ValidE, 1);
        lit("rel_rd", RdE, saved.rd);
        lit("rel_pc", PCE, saved.pc);
        nxt(); load_d(5, 1, 2); #3;
        lit("pt_alu", ALUControlE, 6'h05);
        lit("pt_rd1", RD1E, 32'h1234_5678);
        lit("pt_rd", RdE, 7);
        lit("pt_valid", ValidE, 1);
        nxt();
        d = '0; d.rs1 = 5'd9; d.rs2 = 5'd5; d.rd = 5'd10; d.regwrite = 3'd1;
        #3;
        lit("lu_stallf", StallF, 1);
        lit("lu_stalld", StallD, 1);
        nxt(); #3;
        lit("lu_bub_valid", ValidE, 0);
        lit("lu_bub_rw", RegWriteE, 0);
        lit("lu_cnt", BubbleCnt, 1);
        lit("lu_clear", StallF, 0);
        nxt(); #3;
        lit("lu_cap_rd", RdE, 10);
        lit("lu_cap_valid", ValidE, 1);
        load_d(0, 0, 0);
        nxt();
        d = '0; d.rd = 5'd3; d.regwrite = 3'd1;
        #3 lit("x0_stall", StallF, 0);
        nxt(); d = '0; d.rs1 = 5'd3;
        #3 lit("alu_stall", StallF, 0);
        load_d(4, 0, 0);
        nxt(); d.rs1 = 5'd4; flush = 1; stall = 1;
        #3 lit("fl_stall", StallF, 1);
        nxt(); flush = 0; stall = 0;
        #3;
        lit("fl_valid", ValidE, 0);
        lit("fl_cnt", BubbleCnt, 1);
        lit("fl_rd", RdE, 0);
        d = '0; d.rd1 = 32'hCAFE_F00D; d.rd = 5'd12; d.aluctl = 6'h2a;
        nxt(); stall = 1; rand_d();
        repeat (3) begin
            nxt(); rand_d(); #3;
            lit("hold_rd1", RD1E, 32'hCAFE_F00D);
            lit("hold_rd", RdE, 12);
            lit("hold_alu", ALUControlE, 6'h2a);
            lit("hold_stalld", StallD, 1);
        end
        nxt(); stall = 0; load_d(5, 5, 5);
        repeat (600) nxt();
        #3 lit("sat", BubbleCnt, 8'hFF);
        repeat (3) nxt();
        #3 lit("sat_hold", BubbleCnt, 8'hFF);
        nxt(); stall = 1; flush = 1;
        #3 rst = 0;
        #1;
        lit("mid_rst_valid", ValidE, 0);
        lit("mid_rst_cnt", BubbleCnt, 0);
        lit("mid_rst_rd", RdE, 0);
        nxt(); rst = 1; stall = 0; flush = 0;
        repeat (3000) begin
            nxt(); rand_d();
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 6) == 0);
        end
        nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage RV32 core.
- Sits directly downstream of the control unit and register file. Captures their decode-stage (D) control and data outputs and presents them to the execute stage (E).
- Owns load-use hazard detection: inserts a bubble into E and stalls IF/ID when needed.
- Implements flush, for taken branches and jumps, and hold, for a multi-cycle execute, with a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- RegWriteD  in  3  register-write control from the control unit; nonzero means write.
- ALUSrcD  in  1  ALU B-operand select.
- MemWriteD  in  2  store control.
- ResultSrcD  in  2  writeback select; 2'b01 denotes a load.
- BranchD  in  1  branch instruction.
- JumpD  in  1  jump instruction.
- ALUControlD  in  6  ALU operation.
- CSR_reg_wrD  in  1  CSR write enable.
- CSR_reg_rdD  in  1  CSR read enable.
- CSR_wd_selectD  in  2  CSR write-data select.
- RD1_RS1_selD  in  1  RD1/RS1 operand select.
- funct3D  in  3  funct3 passthrough for branch compare and load/store size.
- RD1D  in  XLEN  register file read data 1.
- RD2D  in  XLEN  register file read data 2.
- ImmExtD  in  XLEN  extended immediate.
- PCD  in  XLEN  PC of the decode instruction.
- PCPlus4D  in  XLEN  PC+4 of the decode instruction.
- RS1D  in  5  source register index 1.
- RS2D  in  5  source register index 2.
- RdD  in  5  destination register index.
- FlushE  in  1  squash the instruction entering E (taken branch or jump).
- StallE  in  1  hold the E register (downstream multi-cycle op).
- All ...E outputs  out  same widths as the matching ...D inputs  registered copies of the inputs.
- ValidE  out  1  E holds a real instruction.
- StallF  out  1  hold the PC.
- StallD  out  1  hold the IF/ID register.
- BubbleCnt  out  CNT_W  count of inserted load-use bubbles, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all E outputs, ValidE and BubbleCnt go to 0. Control-zero is a NOP: no register write, no memory write, no branch, no jump, no CSR access.
- Hazard detect, combinational from current E state and D inputs:
  - hz = ValidE & (ResultSrcE==2'b01) & (RegWriteE!=0) & (RdE!=0) & ((RdE==RS1D)|(RdE==RS2D)).
  - The check is conservative: both sources are always compared.
- StallF = StallD = (hz & ~FlushE) | StallE. Combinational, no latency.
- Per-rising-edge update, in priority order:
  1. FlushE=1: load bubble. All control fields, data fields and indices go to 0; ValidE=0. Flush overrides StallE.
  2. StallE=1: all E registers hold their value. BubbleCnt unchanged.
  3. hz=1: load bubble, as in step 1. BubbleCnt += 1, saturating at all-ones. D is held upstream via StallD, so the same instruction re-presents next cycle.
  4. Otherwise: capture all D inputs into E; ValidE=1.
- Latency: exactly 1 cycle from D inputs to E outputs when no condition in steps 1–3 applies.
- The hazard clears automatically the cycle after the bubble, because ValidE=0 after the bubble and therefore hz=0.
- A flush coinciding with a hazard counts as a flush: no BubbleCnt increment.
- x0 is never a hazard source.
- Reset asserted mid-stall or mid-flush forces the reset values immediately. The first edge after reset release behaves per the priority rules above.
- No combinational path from D inputs to E outputs.

Test Plan:
- Reset: hold rst=0 with random D inputs, then release → all E outputs, ValidE and BubbleCnt are 0 while reset is asserted. First edge after release captures D with ValidE=1.
- Pass-through: ALUControlD=6'h05, RD1D=32'h1234_5678, RdD=7, no stall or flush → one cycle later ALUControlE=6'h05, RD1E=32'h1234_5678, RdE=7, ValidE=1.
- Load-use: E holds a load (ResultSrcE=01, RegWriteE=1, RdE=5); D has RS2D=5 → StallF=StallD=1 the same cycle. Next edge E is a bubble (ValidE=0, RegWriteE=0) and BubbleCnt=1. Following edge captures D; stalls deassert.
- x0 and non-load: E load with RdE=0 and RS1D=0 → no stall. E ALU op (ResultSrcE=00) with RdE=RS1D=3 → no stall.
- Flush priority: FlushE=1 together with StallE=1 and a hazard → E becomes a bubble, ValidE=0, BubbleCnt unchanged.
- Hold and saturation: StallE=1 for 3 cycles while D changes → E outputs stay constant and StallD=1. Preload BubbleCnt to 16'hFFFF via repeated hazards, then trigger another → BubbleCnt stays 16'hFFFF.
